// File: rtl/spi_sd_pkg.sv
// Shared constants and types for the SD-card SPI host: register offsets,
// CTRL/STATUS bit positions, operating modes and the transfer FSM states.
package spi_sd_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_DIV    = 2'd3;

   localparam int CTRL_MODE_BIT   = 7;
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_OVR_BIT  = 1;

   typedef enum logic {
      MODE_LEGACY = 1'b0,
      MODE_HW     = 1'b1
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } hw_state_e;

endpackage

// File: rtl/spi_sd_shifter.sv
// SPI engine: owns SCK, MOSI and the shift register. Runs mode-0 byte
// transfers on a divided tick and applies the single-step legacy commands.
module spi_sd_shifter
   import spi_sd_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk64,
   input  logic             reset,
   input  logic             start,
   input  logic [7:0]       start_data,
   input  logic [DIV_W-1:0] div,
   input  logic             legacy_wr,
   input  logic             legacy_bit,
   input  logic             legacy_clk_set,
   input  logic             force_idle,
   input  logic             sd_miso,
   output logic [7:0]       shreg,
   output hw_state_e        state,
   output logic             sd_clk,
   output logic             sd_mosi
);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_lat;
   logic [3:0]       tick_cnt;
   logic             samp;

   always_ff @(posedge clk64 or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= 8'hFF;
         sd_clk   <= 1'b0;
         sd_mosi  <= 1'b1;
         div_cnt  <= '0;
         div_lat  <= '0;
         tick_cnt <= 4'd0;
         samp     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (force_idle) begin
                  sd_clk  <= 1'b0;
                  sd_mosi <= 1'b1;
               end else if (start) begin
                  // Divider is latched here so DIV writes mid-byte only affect the next byte.
                  shreg    <= start_data;
                  sd_mosi  <= start_data[7];
                  sd_clk   <= 1'b0;
                  div_cnt  <= '0;
                  div_lat  <= div;
                  tick_cnt <= 4'd0;
                  state    <= XFER;
               end else if (legacy_wr) begin
                  // Old port kept a 7-bit history, so bit7 clears on every legacy shift.
                  if (sd_clk)
                     shreg <= {1'b0, shreg[5:0], sd_miso};
                  sd_mosi <= legacy_bit;
                  sd_clk  <= 1'b0;
               end else if (legacy_clk_set) begin
                  sd_clk <= 1'b1;
               end
            end
            XFER: begin
               if (div_cnt == div_lat) begin
                  div_cnt  <= '0;
                  tick_cnt <= tick_cnt + 4'd1;
                  if (!tick_cnt[0]) begin
                     sd_clk <= 1'b1;
                     samp   <= sd_miso;
                  end else begin
                     sd_clk <= 1'b0;
                     shreg  <= {shreg[6:0], samp};
                     if (tick_cnt == 4'd15) begin
                        sd_mosi <= 1'b1;
                        state   <= IDLE;
                     end else begin
                        sd_mosi <= shreg[6];
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/spi_sd_host.sv
// CPU-bus SD-card SPI host: 4-byte register window, strobe edge detection,
// register file, legacy bit-bang path and the combinational read mux.
module spi_sd_host
   import spi_sd_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR   = 16'hF700,
   parameter int          NUM_CS      = 1,
   parameter int          DIV_W       = 8,
   parameter int          DEFAULT_DIV = 79
) (
   input  logic              clk64,
   input  logic              reset,
   input  logic [15:0]       adr,
   input  logic [7:0]        data_in,
   input  logic              we_n,
   input  logic              oe_n,
   output logic [7:0]        rd_data,
   output logic              rd_sel,
   output logic              sd_clk,
   output logic              sd_mosi,
   input  logic              sd_miso,
   output logic [NUM_CS-1:0] sd_cs_n
);

   logic              we_q, oe_q;
   logic              in_win, wr_ev, rd_ev;
   logic [1:0]        off;
   mode_e             mode;
   logic [NUM_CS-1:0] cs;
   logic [DIV_W-1:0]  div;
   logic              ovr, busy;
   hw_state_e         hw_state;
   logic [7:0]        shreg;
   logic              wr_ctrl, wr_data, wr_div, rd_status, ctrl_ok;
   logic              force_idle, hw_start, legacy_wr, legacy_clk_set;

   assign off       = adr[1:0];
   assign in_win    = (adr[15:2] == BASE_ADDR[15:2]);
   assign wr_ev     = we_q & ~we_n & in_win;
   assign rd_ev     = oe_q & ~oe_n & in_win;
   assign wr_ctrl   = wr_ev & (off == REG_CTRL);
   assign wr_data   = wr_ev & (off == REG_DATA);
   assign wr_div    = wr_ev & (off == REG_DIV);
   assign rd_status = rd_ev & (off == REG_STATUS);
   assign busy      = (hw_state == XFER);
   assign ctrl_ok   = wr_ctrl & ~busy;

   assign force_idle     = ctrl_ok & (data_in[CTRL_MODE_BIT] != (mode == MODE_HW));
   assign hw_start       = wr_data & ~busy & (mode == MODE_HW);
   assign legacy_wr      = wr_data & (mode == MODE_LEGACY);
   // Legacy software relies on any read cycle raising SCK, whatever the address.
   assign legacy_clk_set = ~oe_n & (mode == MODE_LEGACY);

   assign rd_sel  = ~oe_n & in_win;
   assign sd_cs_n = ~cs;

   always_ff @(posedge clk64 or posedge reset) begin
      if (reset) begin
         we_q <= 1'b1;
         oe_q <= 1'b1;
         mode <= MODE_LEGACY;
         cs   <= '0;
         div  <= DIV_W'(DEFAULT_DIV);
         ovr  <= 1'b0;
      end else begin
         we_q <= we_n;
         oe_q <= oe_n;
         if (ctrl_ok) begin
            cs   <= data_in[NUM_CS-1:0];
            mode <= mode_e'(data_in[CTRL_MODE_BIT]);
         end
         if (wr_div)
            div <= data_in[DIV_W-1:0];
         // A new overrun beats a simultaneous STATUS read clear.
         if (busy & (wr_ctrl | wr_data))
            ovr <= 1'b1;
         else if (rd_status)
            ovr <= 1'b0;
      end
   end

   always_comb begin
      rd_data = 8'h00;
      case (off)
         REG_CTRL: begin
            rd_data[NUM_CS-1:0]   = cs;
            rd_data[CTRL_MODE_BIT] = (mode == MODE_HW);
         end
         REG_DATA:
            rd_data = (mode == MODE_HW) ? shreg : {shreg[6:0], sd_miso};
         REG_STATUS: begin
            rd_data[STATUS_BUSY_BIT] = busy;
            rd_data[STATUS_OVR_BIT]  = ovr;
         end
         default:
            rd_data[DIV_W-1:0] = div;
      endcase
   end

   spi_sd_shifter #(
      .DIV_W(DIV_W)
   ) u_shifter (
      .clk64          (clk64),
      .reset          (reset),
      .start          (hw_start),
      .start_data     (data_in),
      .div            (div),
      .legacy_wr      (legacy_wr),
      .legacy_bit     (data_in[7]),
      .legacy_clk_set (legacy_clk_set),
      .force_idle     (force_idle),
      .sd_miso        (sd_miso),
      .shreg          (shreg),
      .state          (hw_state),
      .sd_clk         (sd_clk),
      .sd_mosi        (sd_mosi)
   );

endmodule

// File: tb/tb_spi_sd_host.sv
// Bench for spi_sd_host: CPU bus driver tasks, a read scoreboard fed from a
// register-level model, and SCK edge timing checks for hardware transfers.
module tb_spi_sd_host;

   localparam logic [15:0] BASE = 16'hF700;
   localparam logic [1:0]  O_CTRL = 2'd0, O_DATA = 2'd1, O_STATUS = 2'd2, O_DIV = 2'd3;

   // ---------------- clock / reset ----------------
   logic        clk64 = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] adr = BASE;
   logic [7:0]  data_in = 8'h00;
   logic        we_n = 1'b1;
   logic        oe_n = 1'b1;
   logic [7:0]  rd_data;
   logic        rd_sel, sd_clk, sd_mosi, sd_miso;
   logic [0:0]  sd_cs_n;
   logic        loop_en = 1'b0;
   logic        miso_val = 1'b0;

   assign sd_miso = loop_en ? sd_mosi : miso_val;

   always #8 clk64 = ~clk64;

   int cyc = 0;
   always @(posedge clk64) cyc <= cyc + 1;

   spi_sd_host dut (
      .clk64   (clk64),
      .reset   (reset),
      .adr     (adr),
      .data_in (data_in),
      .we_n    (we_n),
      .oe_n    (oe_n),
      .rd_data (rd_data),
      .rd_sel  (rd_sel),
      .sd_clk  (sd_clk),
      .sd_mosi (sd_mosi),
      .sd_miso (sd_miso),
      .sd_cs_n (sd_cs_n)
   );

   // ---------------- counters / scoreboard ----------------
   int          n_checks = 0;
   int          n_pass = 0;
   logic [7:0]  exp_q[$];
   string       name_q[$];
   int          edge_q[$];
   int          last_wr_cyc = 0;
   int          xfer_cyc = 0;

   // Register-level model of the block as software sees it.
   logic        m_mode;
   logic        m_cs;
   logic [7:0]  m_div;
   logic [7:0]  m_sh;
   logic        m_clk;
   logic        m_mosi;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      m_mode = 1'b0;
      m_cs   = 1'b0;
      m_div  = 8'd79;
      m_sh   = 8'hFF;
      m_clk  = 1'b0;
      m_mosi = 1'b1;
   endtask

   function automatic logic [7:0] exp_reg(input logic [1:0] off);
      case (off)
         O_CTRL:   return {m_mode, 6'b0, m_cs};
         O_DATA:   return m_mode ? m_sh : {m_sh[6:0], miso_val};
         O_STATUS: return 8'h00;
         default:  return m_div;
      endcase
   endfunction

   // Monitor: every new read strobe inside the window is checked against the queue.
   logic sel_prev = 1'b0;
   always @(negedge clk64) begin
      if (rd_sel && !sel_prev) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_read: got 0x%0h expected no read", rd_data);
         end else begin
            chk(name_q.pop_front(), rd_data, exp_q.pop_front());
         end
      end
      sel_prev = rd_sel;
   end

   // SCK edge recorder, timestamped in clk64 cycles.
   logic sck_prev = 1'b0;
   always @(negedge clk64) begin
      if (sd_clk !== sck_prev) begin
         edge_q.push_back(cyc);
         sck_prev = sd_clk;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cpu_write(input logic [1:0] off, input logic [7:0] d, input int hold);
      @(posedge clk64); #1;
      adr = BASE | 16'(off);
      data_in = d;
      we_n = 1'b0;
      last_wr_cyc = cyc;
      repeat (hold) @(posedge clk64);
      #1 we_n = 1'b1;
      repeat (2) @(posedge clk64);
   endtask

   task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string name);
      @(posedge clk64); #1;
      adr = a;
      if (a[15:2] == BASE[15:2]) begin
         exp_q.push_back(exp);
         name_q.push_back(name);
      end
      oe_n = 1'b0;
      if (!m_mode) m_clk = 1'b1;
      repeat (2) @(posedge clk64);
      #1 oe_n = 1'b1;
      @(posedge clk64);
   endtask

   task automatic rd(input logic [1:0] off, input string name);
      cpu_read(BASE | 16'(off), exp_reg(off), name);
   endtask

   task automatic rd_exp(input logic [1:0] off, input logic [7:0] exp, input string name);
      cpu_read(BASE | 16'(off), exp, name);
   endtask

   // Write that is accepted (not busy); the model follows the register rules.
   task automatic wr(input logic [1:0] off, input logic [7:0] d);
      case (off)
         O_CTRL: begin
            if (d[7] != m_mode) begin
               m_clk  = 1'b0;
               m_mosi = 1'b1;
            end
            m_cs   = d[0];
            m_mode = d[7];
         end
         O_DATA: begin
            if (!m_mode) begin
               if (m_clk) m_sh = {1'b0, m_sh[5:0], miso_val};
               m_mosi = d[7];
               m_clk  = 1'b0;
            end
         end
         O_DIV: m_div = d;
         default: ;
      endcase
      cpu_write(off, d, 3);
   endtask

   task automatic start_xfer(input logic [7:0] d, input int hold);
      edge_q.delete();
      cpu_write(O_DATA, d, hold);
      xfer_cyc = last_wr_cyc;
   endtask

   // A byte takes 16 half-bit ticks of (div+1) cycles, the first one
   // counted from the cycle after the write event.
   task automatic finish_xfer(input int dv, input logic [7:0] exp_rx);
      int n;
      for (int i = 0; i < 16 * (dv + 1) + 64; i++) begin
         if (edge_q.size() >= 16) break;
         @(negedge clk64);
      end
      chk("sck_edge_count", edge_q.size(), 16);
      n = (edge_q.size() < 16) ? edge_q.size() : 16;
      for (int m = 0; m < n; m++)
         chk($sformatf("sck_edge_%0d_time", m), edge_q[m], xfer_cyc + 1 + (m + 1) * (dv + 1));
      m_sh   = exp_rx;
      m_mosi = 1'b1;
      m_clk  = 1'b0;
      repeat (3) @(posedge clk64);
      #1;
      chk("xfer_end_sck", sd_clk, m_clk);
      chk("xfer_end_mosi", sd_mosi, m_mosi);
      rd_exp(O_STATUS, 8'h00, "xfer_end_status");
      rd(O_DATA, "xfer_rx_data");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] d, d2;
      int         op, dv;

      model_reset();
      repeat (4) @(posedge clk64);
      #1 reset = 1'b0;
      chk("rst_cs_n", sd_cs_n, 1);
      chk("rst_sck", sd_clk, 0);
      chk("rst_mosi", sd_mosi, 1);
      rd(O_CTRL, "rst_ctrl");
      rd(O_STATUS, "rst_status");
      rd(O_DIV, "rst_div");

      // Legacy bit-bang behaviour
      wr(O_CTRL, 8'h01);
      chk("leg_cs_n", sd_cs_n, 0);
      wr(O_DATA, 8'h80);
      chk("leg_mosi_hi", sd_mosi, 1);
      chk("leg_sck_lo", sd_clk, 0);
      rd(O_CTRL, "leg_ctrl");
      chk("leg_sck_after_read", sd_clk, m_clk);
      miso_val = 1'b0;
      for (int i = 0; i < 7; i++) begin
         rd(O_DATA, "leg_clear_data");
         wr(O_DATA, 8'h80);
      end
      rd(O_DATA, "leg_pre_data");
      miso_val = 1'b1;
      wr(O_DATA, 8'h00);
      chk("leg_mosi_lo", sd_mosi, m_mosi);
      miso_val = 1'b0;
      rd(O_DATA, "leg_data_02");

      for (int i = 0; i < 12; i++) begin
         op = $urandom_range(0, 2);
         miso_val = 1'($urandom_range(0, 1));
         case (op)
            0: wr(O_DATA, 8'($urandom_range(0, 255)));
            1: rd(2'($urandom_range(0, 3)), "leg_rand_read");
            default: cpu_read(16'h1234, 8'h00, "outside");
         endcase
         chk("leg_rand_sck", sd_clk, m_clk);
         chk("leg_rand_mosi", sd_mosi, m_mosi);
      end

      // Switch to hardware mode from a state with SCK high and MOSI low
      miso_val = 1'b0;
      wr(O_DATA, 8'h00);
      rd(O_STATUS, "pre_mode_status");
      chk("pre_mode_sck", sd_clk, 1);
      wr(O_CTRL, 8'h81);
      chk("mode_chg_sck", sd_clk, m_clk);
      chk("mode_chg_mosi", sd_mosi, m_mosi);
      rd(O_CTRL, "hw_ctrl");

      // Fastest clock, MISO looped to MOSI
      loop_en = 1'b1;
      wr(O_DIV, 8'h00);
      start_xfer(8'hA5, 3);
      finish_xfer(0, 8'hA5);
      for (int i = 0; i < 4; i++) begin
         dv = $urandom_range(0, 3);
         d  = 8'($urandom_range(0, 255));
         wr(O_DIV, 8'(dv));
         start_xfer(d, 3);
         finish_xfer(dv, d);
      end

      // Default divider, MISO low, conflicting writes mid-transfer
      loop_en = 1'b0;
      miso_val = 1'b0;
      wr(O_DIV, 8'd79);
      start_xfer(8'hFF, 3);
      repeat (100) @(posedge clk64);
      rd_exp(O_STATUS, 8'h01, "busy_status");
      cpu_write(O_DATA, 8'h11, 3);
      rd_exp(O_STATUS, 8'h03, "ovr_status");
      cpu_write(O_CTRL, 8'h00, 3);
      rd(O_CTRL, "ctrl_kept_while_busy");
      rd_exp(O_STATUS, 8'h03, "ovr_again_status");
      finish_xfer(79, 8'h00);

      // Held write strobe must give exactly one transfer
      loop_en = 1'b1;
      wr(O_DIV, 8'h00);
      d = 8'($urandom_range(0, 255));
      start_xfer(d, 20);
      finish_xfer(0, d);
      repeat (10) @(posedge clk64);
      chk("held_single_xfer", edge_q.size(), 16);

      // DIV written mid-byte applies to the next byte only
      wr(O_DIV, 8'd3);
      d  = 8'($urandom_range(0, 255));
      d2 = 8'($urandom_range(0, 255));
      start_xfer(d, 3);
      wr(O_DIV, 8'd1);
      finish_xfer(3, d);
      start_xfer(d2, 3);
      finish_xfer(1, d2);
      rd(O_DIV, "div_new");

      // Reset in the middle of a slow transfer, SCK high and MOSI low
      loop_en = 1'b0;
      miso_val = 1'b0;
      wr(O_DIV, 8'd79);
      start_xfer(8'h3C, 3);
      repeat (250) @(posedge clk64);
      chk("pre_rst_sck", sd_clk, 1);
      #3 reset = 1'b1;
      #1;
      model_reset();
      chk("midrst_cs_n", sd_cs_n, 1);
      chk("midrst_sck", sd_clk, 0);
      chk("midrst_mosi", sd_mosi, 1);
      repeat (3) @(posedge clk64);
      #1 reset = 1'b0;
      rd(O_CTRL, "midrst_ctrl");
      rd(O_STATUS, "midrst_status");
      rd(O_DIV, "midrst_div");
      rd(O_DATA, "midrst_data");

      repeat (10) @(posedge clk64);
      chk("scoreboard_drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule
